// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and framing constants for the program loader
package loader_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int CSUM_WIDTH     = 8;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - assembles big-endian bytes into instruction words
module loader_word_packer
   import loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  data,
   input  logic                        shift_en,
   input  logic                        clear,
   output logic [BYTES_PER_WORD*8-1:0] word,
   output logic                        word_complete
);

   localparam int WORD_W = BYTES_PER_WORD * 8;

   logic [WORD_W-1:0] sr;
   logic [1:0]        idx;

   // word_complete is registered so it lines up with the fully shifted word
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sr            <= '0;
         idx           <= '0;
         word_complete <= 1'b0;
      end else begin
         word_complete <= shift_en && (idx == 2'(BYTES_PER_WORD - 1));
         if (shift_en) begin
            sr  <= {sr[WORD_W-9:0], data};
            idx <= idx + 2'd1;
         end
      end
   end

   assign word = sr;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction memory loader; LOADER_WDT_EN adds an inter-byte watchdog
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int INST_WIDTH     = 32,
   parameter int MAX_WORDS      = 256,
   parameter int BASE_ADDR      = 0,
   parameter int TIMEOUT_CYCLES = 1000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [INST_WIDTH-1:0] im_wdata,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  error
);

   localparam int LEN_W = LEN_BYTES * 8;
   localparam int CNT_W = LEN_W + $clog2(BYTES_PER_WORD);

   logic [2:0]            state;
   logic [LEN_W-1:0]      len;
   logic [CNT_W-1:0]      count;
   logic [CSUM_WIDTH-1:0] csum;
   logic [LEN_W-1:0]      len_next;
   logic                  accept;
   logic                  load_start;
   logic                  wdt_expire;

   assign rx_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
   assign accept     = rx_valid && rx_ready;
   assign load_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign len_next   = {len[LEN_W-1:8], rx_data};

   assign cpu_rst = (state != S_DONE);
   assign done    = (state == S_DONE);
   assign error   = (state == S_ERR);

   loader_word_packer u_packer (
      .clk           (clk),
      .rst           (rst),
      .data          (rx_data),
      .shift_en      (accept && (state == S_DATA)),
      .clear         (load_start),
      .word          (im_wdata),
      .word_complete (im_we)
   );

   // count tracks data bytes so the last byte steers to CSUM before its write pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         len     <= '0;
         count   <= '0;
         csum    <= '0;
         im_addr <= ADDR_WIDTH'(BASE_ADDR);
      end else begin
         if (im_we)
            im_addr <= im_addr + ADDR_WIDTH'(BYTES_PER_WORD);
         if (load_start) begin
            state   <= S_LEN_HI;
            count   <= '0;
            csum    <= '0;
            im_addr <= ADDR_WIDTH'(BASE_ADDR);
         end else if (wdt_expire) begin
            state <= S_ERR;
         end else if (accept) begin
            case (state)
               S_LEN_HI: begin
                  len[LEN_W-1:8] <= rx_data;
                  state          <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  len[7:0] <= rx_data;
                  if (32'(len_next) > 32'(MAX_WORDS))
                     state <= S_ERR;
                  else if (len_next == '0)
                     state <= S_CSUM;
                  else
                     state <= S_DATA;
               end
               S_DATA: begin
                  csum  <= csum ^ rx_data;
                  count <= count + CNT_W'(1);
                  if ((count + CNT_W'(1)) == {len, 2'b00})
                     state <= S_CSUM;
               end
               S_CSUM:  state <= (rx_data == csum) ? S_DONE : S_ERR;
               default: ;
            endcase
         end
      end
   end

`ifdef LOADER_WDT_EN
   logic [31:0] wdt_cnt;

   assign wdt_expire = rx_ready && !accept && ((wdt_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (rst || load_start || accept || !rx_ready)
         wdt_cnt <= '0;
      else
         wdt_cnt <= wdt_cnt + 32'd1;
   end
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign wdt_expire     = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

   localparam int MAX_WORDS = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;
   logic        cpu_rst;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] words[$];
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];

   always #5 clk = ~clk;

   program_loader #(
      .ADDR_WIDTH     (32),
      .INST_WIDTH     (32),
      .MAX_WORDS      (MAX_WORDS),
      .BASE_ADDR      (0),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .error    (error)
   );

   always @(negedge clk) begin
      if (im_we) begin
         got_addr.push_back(im_addr);
         got_data.push_back(im_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50)
         check("rx_ready_wait", 64'(rx_ready), 64'd1);
      else
         @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_load(input string tag, input int len, input bit force_csum,
                           input logic [7:0] csum_in, input int gap_max, input bit mid_start);
      logic [7:0] ref_csum;
      logic [7:0] sent_csum;
      logic [7:0] b;
      bit         exp_done;
      ref_csum = 8'h00;
      got_addr.delete();
      got_data.delete();
      pulse_start();
      send_byte(8'(len >> 8), $urandom_range(gap_max, 0));
      send_byte(8'(len), $urandom_range(gap_max, 0));
      if (len > MAX_WORDS) begin
         repeat (2) @(negedge clk);
         check({tag, "_error"}, 64'(error), 64'd1);
         check({tag, "_ready"}, 64'(rx_ready), 64'd0);
         check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
         rx_valid = 1'b1;
         rx_data  = 8'hA5;
         repeat (3) @(negedge clk);
         rx_valid = 1'b0;
         check({tag, "_hold_error"}, 64'(error), 64'd1);
         check({tag, "_nwr"}, 64'(got_addr.size()), 64'd0);
         return;
      end
      for (int i = 0; i < len; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = words[i][31 - 8*k -: 8];
            ref_csum = ref_csum ^ b;
            if (mid_start && i == len / 2 && k == 1)
               pulse_start();
            send_byte(b, $urandom_range(gap_max, 0));
         end
      end
      sent_csum = force_csum ? csum_in : ref_csum;
      send_byte(sent_csum, $urandom_range(gap_max, 0));
      repeat (2) @(negedge clk);
      exp_done = (sent_csum == ref_csum);
      check({tag, "_nwr"}, 64'(got_addr.size()), 64'(len));
      for (int i = 0; i < len && i < got_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(4 * i));
         check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(words[i]));
      end
      check({tag, "_done"}, 64'(done), 64'(exp_done));
      check({tag, "_error"}, 64'(error), 64'(!exp_done));
      check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
      check({tag, "_ready"}, 64'(rx_ready), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_rx_ready", 64'(rx_ready), 64'd0);
      check("rst_im_we", 64'(im_we), 64'd0);
      check("rst_im_addr", 64'(im_addr), 64'd0);
      check("rst_im_wdata", 64'(im_wdata), 64'd0);
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      words = '{32'h20080005, 32'h0000000C};
      run_load("nominal", 2, 1'b1, 8'h21, 0, 1'b0);
      run_load("bad_csum", 2, 1'b1, 8'h22, 0, 1'b0);
      run_load("reload", 2, 1'b0, 8'h00, 0, 1'b0);
      run_load("oversize", 257, 1'b0, 8'h00, 0, 1'b0);
      words.delete();
      run_load("zero_ok", 0, 1'b1, 8'h00, 0, 1'b0);
      run_load("zero_bad", 0, 1'b1, 8'h01, 0, 1'b0);

      // reset lands on the same edge as the last byte of word 0
      got_addr.delete();
      got_data.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      rx_valid = 1'b1;
      rx_data  = 8'h44;
      rst      = 1'b1;
      @(negedge clk);
      check("midrst_im_we", 64'(im_we), 64'd0);
      check("midrst_im_addr", 64'(im_addr), 64'd0);
      check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("midrst_ready", 64'(rx_ready), 64'd0);
      rst      = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_nwr", 64'(got_addr.size()), 64'd0);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(6, 1);
         words.delete();
         for (int i = 0; i < n; i++)
            words.push_back($urandom);
         run_load($sformatf("rand%0d", r), n, (r % 3) == 2, 8'($urandom), 3, (r % 2) == 1);
      end

`ifdef LOADER_WDT_EN
      words = '{32'hDEADBEEF};
      got_addr.delete();
      got_data.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      repeat (9) @(negedge clk);
      check("wdt9_error", 64'(error), 64'd0);
      send_byte(8'hBE, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0);
      repeat (2) @(negedge clk);
      check("wdt9_done", 64'(done), 64'd1);
      check("wdt9_nwr", 64'(got_addr.size()), 64'd1);

      got_addr.delete();
      got_data.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hDE, 0);
      repeat (9) @(negedge clk);
      check("wdt10_pre_error", 64'(error), 64'd0);
      @(negedge clk);
      check("wdt10_error", 64'(error), 64'd1);
      check("wdt10_cpu_rst", 64'(cpu_rst), 64'd1);
      check("wdt10_ready", 64'(rx_ready), 64'd0);
      repeat (4) @(negedge clk);
      check("wdt10_nwr", 64'(got_addr.size()), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
